if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage_pkg.sv | 19 +
 rtl/if_id_stage_load_use_detect.sv | 28 ++
 rtl/if_id_stage.sv | 65 ++++++
 tb/tb_if_id_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared field positions, widths and counter helper for the IF/ID stage
package if_id_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int CNT_W   = 32;
  localparam int REG_W   = 5;
  localparam int XZR     = 31;

  localparam int RT_LSB  = 0;
  localparam int RN_LSB  = 5;
  localparam int RM_LSB  = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// rtl/if_id_stage_load_use_detect.sv - load-use hazard between the load in EX and the instruction in ID
module load_use_detect
  import if_id_stage_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_D,
  input  logic               valid_D,
  input  logic               memRead_E,
  input  logic [REG_W-1:0]   rd_E,
  output logic               hazard
);

  logic [REG_W-1:0] rn;
  logic [REG_W-1:0] rm;
  logic [REG_W-1:0] rt;
  logic             unused_bits;

  assign rn = instr_D[RN_LSB +: REG_W];
  assign rm = instr_D[RM_LSB +: REG_W];
  assign rt = instr_D[RT_LSB +: REG_W];

  // Opcode/shift bits never name a register; kept only so every input bit is consumed.
  assign unused_bits = ^{instr_D[31:21], instr_D[15:10]};

  // Rt is compared even for formats where it is a destination; a spurious stall is harmless.
  assign hazard = valid_D & memRead_E & (rd_E != REG_W'(XZR)) &
                  ((rd_E == rn) | (rd_E == rm) | (rd_E == rt));

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with load-use stall, branch flush and event counters
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int size = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [size-1:0]     imem_addr_F,
  input  logic [INSTR_W-1:0]  imem_data_F,
  input  logic                flush_D,
  input  logic                memRead_E,
  input  logic [REG_W-1:0]    rd_E,
  output logic                enable_F,
  output logic [size-1:0]     pc_D,
  output logic [INSTR_W-1:0]  instr_D,
  output logic                valid_D,
  output logic                bubble_D,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  logic hazard;
  logic stall;

  load_use_detect u_load_use_detect (
    .instr_D   (instr_D),
    .valid_D   (valid_D),
    .memRead_E (memRead_E),
    .rd_E      (rd_E),
    .hazard    (hazard)
  );

  // A taken branch squashes the dependent instruction, so there is nothing left to stall for.
  assign stall    = hazard & ~flush_D;
  assign enable_F = ~stall;
  assign bubble_D = stall | ~valid_D;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_D      <= '0;
      instr_D   <= '0;
      valid_D   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush_D) begin
        pc_D    <= '0;
        instr_D <= '0;
        valid_D <= 1'b0;
      end else if (!stall) begin
        pc_D    <= imem_addr_F;
        instr_D <= imem_data_F;
        valid_D <= 1'b1;
      end
      if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (flush_D) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage against a behavioural pipeline model
module tb_if_id_stage;

  localparam logic [31:0] LDUR_X1_X2 = 32'hF8400041;
  localparam longint      SAT        = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr_F;
  logic [31:0] imem_data_F;
  logic        flush_D;
  logic        memRead_E;
  logic [4:0]  rd_E;
  logic        enable_F;
  logic [63:0] pc_D;
  logic [31:0] instr_D;
  logic        valid_D;
  logic        bubble_D;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always #5 clk = ~clk;

  if_id_stage #(.size(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr_F (imem_addr_F),
    .imem_data_F (imem_data_F),
    .flush_D     (flush_D),
    .memRead_E   (memRead_E),
    .rd_E        (rd_E),
    .enable_F    (enable_F),
    .pc_D        (pc_D),
    .instr_D     (instr_D),
    .valid_D     (valid_D),
    .bubble_D    (bubble_D),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  typedef struct {
    logic        en;
    logic        bub;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
    bit          cnt_chk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Model of what the ID register should hold right now; counters are unbounded event counts.
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  longint      m_sc;
  longint      m_fc;
  bit          skip_cnt = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] clip(input longint v);
    longint c;
    c = (v > SAT) ? SAT : v;
    return c[31:0];
  endfunction

  function automatic int field(input logic [31:0] w, input int lsb);
    return int'((w >> lsb) & 32'h1F);
  endfunction

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_valid = 1'b0; m_sc = 0; m_fc = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc_D, 64'h0);
    chk({tag, "_instr"}, {32'h0, instr_D}, 64'h0);
    chk({tag, "_valid"}, {63'h0, valid_D}, 64'h0);
    chk({tag, "_enable"}, {63'h0, enable_F}, 64'h1);
    chk({tag, "_bubble"}, {63'h0, bubble_D}, 64'h1);
    chk({tag, "_stall_cnt"}, {32'h0, stall_cnt}, 64'h0);
    chk({tag, "_flush_cnt"}, {32'h0, flush_cnt}, 64'h0);
  endtask

  // Called at a falling edge: drive one cycle of inputs, queue the expected view, advance the model.
  task automatic step(input logic [63:0] a, input logic [31:0] d, input bit fl, input bit mr,
                      input logic [4:0] rd);
    exp_t e;
    bit   hz;
    bit   st;
    int   r;
    imem_addr_F = a; imem_data_F = d; flush_D = fl; memRead_E = mr; rd_E = rd;
    r  = int'(rd);
    hz = m_valid && mr && (r != 31) &&
         (r == field(m_instr, 5) || r == field(m_instr, 16) || r == field(m_instr, 0));
    st = hz && !fl;
    e.en = !st; e.bub = st || !m_valid;
    e.pc = m_pc; e.instr = m_instr; e.valid = m_valid;
    e.sc = clip(m_sc); e.fc = clip(m_fc); e.cnt_chk = !skip_cnt;
    q.push_back(e);
    if (fl) begin
      m_pc = '0; m_instr = '0; m_valid = 1'b0;
    end else if (!st) begin
      m_pc = a; m_instr = d; m_valid = 1'b1;
    end
    if (st) m_sc++;
    if (fl) m_fc++;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("enable_F", {63'h0, enable_F}, {63'h0, e.en});
        chk("bubble_D", {63'h0, bubble_D}, {63'h0, e.bub});
        chk("pc_D", pc_D, e.pc);
        chk("instr_D", {32'h0, instr_D}, {32'h0, e.instr});
        chk("valid_D", {63'h0, valid_D}, {63'h0, e.valid});
        chk("flush_cnt", {32'h0, flush_cnt}, {32'h0, e.fc});
        if (e.cnt_chk) chk("stall_cnt", {32'h0, stall_cnt}, {32'h0, e.sc});
      end
    end
  end

  initial begin : driver
    logic [63:0] a;
    logic [31:0] d;
    logic [4:0]  rd;
    int          pick;

    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      imem_addr_F = {$urandom, $urandom}; imem_data_F = $urandom;
      flush_D = 1'($urandom); memRead_E = 1'b1; rd_E = 5'($urandom);
      @(negedge clk);
      #2;
      check_reset_outputs("in_reset");
    end
    @(negedge clk);
    reset = 1'b1;

    // First capture, then a load-use stall on Rn=2 and its release.
    step(64'h0, LDUR_X1_X2, 1'b0, 1'b0, 5'd0);
    step(64'h4, $urandom, 1'b0, 1'b1, 5'd2);
    step(64'h4, 32'h8B020020, 1'b0, 1'b0, 5'd0);

    // Load into XZR never stalls; then hazard coinciding with a flush.
    step(64'h8, LDUR_X1_X2, 1'b0, 1'b0, 5'd0);
    step(64'hC, LDUR_X1_X2, 1'b0, 1'b1, 5'd31);
    step(64'h10, $urandom, 1'b1, 1'b1, 5'd2);
    step(64'h14, $urandom, 1'b0, 1'b0, 5'd0);

    // Saturation: stall counter preset one below the top, then three stall cycles.
    step(64'h18, LDUR_X1_X2, 1'b0, 1'b0, 5'd0);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    m_sc = 64'hFFFF_FFFE;
    step(64'h1C, 32'h0, 1'b0, 1'b1, 5'd2);
    release dut.stall_cnt;
    skip_cnt = 1'b1;
    step(64'h1C, 32'h0, 1'b0, 1'b1, 5'd1);
    skip_cnt = 1'b0;
    step(64'h1C, 32'h0, 1'b0, 1'b1, 5'd2);
    step(64'h1C, 32'h0, 1'b0, 1'b0, 5'd0);

    // Asynchronous reset between edges while a stall is being asserted.
    step(64'h20, LDUR_X1_X2, 1'b0, 1'b0, 5'd0);
    imem_addr_F = 64'h24; imem_data_F = 32'hD503201F; flush_D = 1'b0;
    memRead_E = 1'b1; rd_E = 5'd2;
    #1;
    chk("pre_reset_stall", {63'h0, enable_F}, 64'h0);
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #1 reset = 1'b1;
    memRead_E = 1'b0;
    model_reset();
    m_pc = 64'h24; m_instr = 32'hD503201F; m_valid = 1'b1;
    @(negedge clk);

    a = 64'h28;
    for (int i = 0; i < 300; i++) begin
      d    = $urandom;
      pick = $urandom_range(0, 5);
      if (pick == 0)      rd = 5'd31;
      else if (pick == 1) rd = 5'(m_instr >> 5);
      else if (pick == 2) rd = 5'(m_instr >> 16);
      else if (pick == 3) rd = 5'(m_instr);
      else                rd = 5'($urandom);
      step(a, d, ($urandom_range(0, 7) == 0), 1'($urandom), rd);
      a = a + 64'h4;
    end

    @(negedge clk);
    #3;
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
